// File: rtl/output_token_writer_pkg.sv
// Shared types and constants for the output token writer and its capture queue.
package output_token_writer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WR_LO = 2'b01,
        WR_HI = 2'b10
    } state_t;

    localparam int unsigned DROP_MAX = 255;

    function automatic int unsigned log2_ceil(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

endpackage

// File: rtl/output_capture_queue.sv
// Circular capture queue of {result,status} pairs with push/pop/clear and an occupancy count.
module output_capture_queue
    import output_token_writer_pkg::*;
#(
    parameter int unsigned depth = 4,
    parameter int unsigned width = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      push,
    input  logic                      pop,
    input  logic [width-1:0]          push_data,
    output logic [width-1:0]          head,
    output logic [log2_ceil(depth):0] count,
    output logic                      full
);

    localparam int unsigned PW = log2_ceil(depth);
    localparam int unsigned CW = PW + 1;

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    assign head = mem[rd_ptr];
    assign full = (count == CW'(depth));

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/output_token_writer.sv
// Serialises captured result/status pairs into lockstep low/high token writes to the output FIFOs.
module output_token_writer
    import output_token_writer_pkg::*;
#(
    parameter int unsigned word_size   = 16,
    parameter int unsigned queue_depth = 4,
    parameter int unsigned buffer_size = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_wr_in,
    input  logic [2*word_size-1:0] result_in,
    input  logic [2*word_size-1:0] status_in,
    input  logic                   clr_in,
    input  logic [word_size-1:0]   pop_out_fifo_result,
    input  logic [word_size-1:0]   pop_out_fifo_status,
    output logic                   wr_out_result,
    output logic [word_size-1:0]   data_out_result,
    output logic                   wr_out_status,
    output logic [word_size-1:0]   data_out_status,
    output logic                   ready_in,
    output logic                   idle,
    output logic                   overflow,
    output logic [7:0]             drop_count
);

    localparam int unsigned TW = 2 * word_size;
    localparam int unsigned CW = log2_ceil(queue_depth) + 1;
    localparam logic [word_size-1:0] BUF_LIM = word_size'(buffer_size);

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   count;
    logic [2*TW-1:0] head;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;
    logic            space;
    logic            wr;
    logic [TW-1:0]   hold_r;
    logic [TW-1:0]   hold_s;

    // A full queue drops the strobe even if the head is popped in the same cycle.
    assign push  = en_wr_in && !full && !clr_in;
    assign drop  = en_wr_in && full && !clr_in;
    assign space = (pop_out_fifo_result < BUF_LIM) && (pop_out_fifo_status < BUF_LIM);

    output_capture_queue #(
        .depth (queue_depth),
        .width (2 * TW)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_in),
        .push      (push),
        .pop       (pop),
        .push_data ({result_in, status_in}),
        .head      (head),
        .count     (count),
        .full      (full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n         = state;
        pop             = 1'b0;
        wr              = 1'b0;
        data_out_result = '0;
        data_out_status = '0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_n = WR_LO;
                end
            end
            WR_LO: begin
                wr              = space;
                data_out_result = hold_r[word_size-1:0];
                data_out_status = hold_s[word_size-1:0];
                if (space) state_n = WR_HI;
            end
            WR_HI: begin
                wr              = space;
                data_out_result = hold_r[TW-1:word_size];
                data_out_status = hold_s[TW-1:word_size];
                if (space) begin
                    if (count != '0) begin
                        pop     = 1'b1;
                        state_n = WR_LO;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (clr_in) begin
            pop     = 1'b0;
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r <= '0;
            hold_s <= '0;
        end else if (pop) begin
            hold_r <= head[2*TW-1:TW];
            hold_s <= head[TW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clr_in) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'(DROP_MAX)) drop_count <= drop_count + 8'd1;
        end
    end

    assign wr_out_result = wr;
    assign wr_out_status = wr;
    assign ready_in      = !full;
    assign idle          = (state == IDLE) && (count == '0);

endmodule

// File: tb/tb_output_token_writer.sv
// Directed bench for output_token_writer: cycle vector table plus hand-written corner sequences.
module tb_output_token_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_wr_in;
    logic [31:0] result_in;
    logic [31:0] status_in;
    logic        clr_in;
    logic [15:0] pop_out_fifo_result;
    logic [15:0] pop_out_fifo_status;
    logic        wr_out_result;
    logic [15:0] data_out_result;
    logic        wr_out_status;
    logic [15:0] data_out_status;
    logic        ready_in;
    logic        idle;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    output_token_writer dut (
        .clk                 (clk),
        .rst                 (rst),
        .en_wr_in            (en_wr_in),
        .result_in           (result_in),
        .status_in           (status_in),
        .clr_in              (clr_in),
        .pop_out_fifo_result (pop_out_fifo_result),
        .pop_out_fifo_status (pop_out_fifo_status),
        .wr_out_result       (wr_out_result),
        .data_out_result     (data_out_result),
        .wr_out_status       (wr_out_status),
        .data_out_status     (data_out_status),
        .ready_in            (ready_in),
        .idle                (idle),
        .overflow            (overflow),
        .drop_count          (drop_count)
    );

    typedef struct {
        logic        en;
        logic [31:0] r;
        logic [31:0] s;
        logic [15:0] pr;
        logic [15:0] ps;
        logic        wr;
        logic [15:0] dr;
        logic [15:0] ds;
        logic        rdy;
        logic        idl;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic en, input logic [31:0] r, input logic [31:0] s,
                                input logic [15:0] pr, input logic [15:0] ps, input logic wr,
                                input logic [15:0] dr, input logic [15:0] ds,
                                input logic rdy, input logic idl);
        vec_t v;
        v.en = en; v.r = r; v.s = s; v.pr = pr; v.ps = ps;
        v.wr = wr; v.dr = dr; v.ds = ds; v.rdy = rdy; v.idl = idl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input logic en, input logic [31:0] r, input logic [31:0] s,
                         input logic [15:0] pr, input logic [15:0] ps, input logic c);
        en_wr_in = en; result_in = r; status_in = s;
        pop_out_fifo_result = pr; pop_out_fifo_status = ps; clr_in = c;
    endtask

    function automatic logic [15:0] ovf_tok(input int n, input logic is_status);
        logic [15:0] base;
        base = is_status ? 16'hD000 : 16'hC000;
        if (n % 2 == 1) base = base | 16'h0100;
        return base + 16'(n / 2);
    endfunction

    initial begin
        int ntok;
        drive(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b0);
        rst = 1'b1;
        #2;
        chk("reset wr_result", 32'(wr_out_result), 32'h0);
        chk("reset wr_status", 32'(wr_out_status), 32'h0);
        chk("reset data", {data_out_result, data_out_status}, 32'h0);
        chk("reset ready/idle", {30'h0, ready_in, idle}, 32'h3);
        chk("reset overflow/drop", {23'h0, overflow, drop_count}, 32'h0);
        nxt(); nxt();
        rst = 1'b0;

        // Single strobe
        vq.push_back(mk(1'b1, 32'h1234_ABCD, 32'h0000_0001, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1));
        vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b1, 16'hABCD, 16'h0001, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b1, 16'h1234, 16'h0000, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1));
        // Three back-to-back strobes
        vq.push_back(mk(1'b1, 32'h0011_0010, 32'h0111_0110, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1));
        vq.push_back(mk(1'b1, 32'h0021_0020, 32'h0121_0120, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0));
        vq.push_back(mk(1'b1, 32'h0031_0030, 32'h0131_0130, 16'h0, 16'h0, 1'b1, 16'h0010, 16'h0110, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b1, 16'h0011, 16'h0111, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b1, 16'h0020, 16'h0120, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b1, 16'h0021, 16'h0121, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b1, 16'h0030, 16'h0130, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b1, 16'h0031, 16'h0131, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1));
        // Status FIFO full stalls WR_LO, then result FIFO full stalls WR_HI once
        vq.push_back(mk(1'b1, 32'hAAAA_5555, 32'hBBBB_6666, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1));
        vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0));
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'h0, 16'd1024, 1'b0, 16'h5555, 16'h6666, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'h0, 16'd1023, 1'b1, 16'h5555, 16'h6666, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'd1024, 16'h0, 1'b0, 16'hAAAA, 16'hBBBB, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b1, 16'hAAAA, 16'hBBBB, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1));

        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].r, vq[i].s, vq[i].pr, vq[i].ps, 1'b0);
            smp();
            chk($sformatf("vec%0d wr_result", i), 32'(wr_out_result), 32'(vq[i].wr));
            chk($sformatf("vec%0d wr_status", i), 32'(wr_out_status), 32'(vq[i].wr));
            chk($sformatf("vec%0d data", i), {data_out_result, data_out_status}, {vq[i].dr, vq[i].ds});
            chk($sformatf("vec%0d ready/idle", i), {30'h0, ready_in, idle}, {30'h0, vq[i].rdy, vq[i].idl});
            nxt();
        end

        // FIFOs full: 7 strobes -> one held, four queued, two dropped
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, {16'(16'hC100 + k), 16'(16'hC000 + k)}, {16'(16'hD100 + k), 16'(16'hD000 + k)},
                  16'd1024, 16'd1024, 1'b0);
            nxt();
        end
        drive(1'b0, 32'h0, 32'h0, 16'd1024, 16'd1024, 1'b0);
        smp();
        chk("full overflow", 32'(overflow), 32'h1);
        chk("full drop_count", 32'(drop_count), 32'd2);
        chk("full ready_in", 32'(ready_in), 32'h0);
        chk("full stalled wr", 32'(wr_out_result | wr_out_status), 32'h0);
        nxt();
        drive(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b0);
        ntok = 0;
        for (int c = 0; c < 40; c++) begin
            smp();
            if (wr_out_result || wr_out_status) begin
                chk("release lockstep", 32'(wr_out_status), 32'(wr_out_result));
                chk($sformatf("release tok%0d", ntok), {data_out_result, data_out_status},
                    {ovf_tok(ntok, 1'b0), ovf_tok(ntok, 1'b1)});
                ntok++;
            end
            nxt();
        end
        chk("release token count", 32'(ntok), 32'd10);
        smp();
        chk("release idle", 32'(idle), 32'h1);
        nxt();

        // Saturate drop_count, then clear it together with an ignored strobe
        for (int k = 0; k < 262; k++) begin
            drive(1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 16'd1024, 16'd1024, 1'b0);
            nxt();
        end
        drive(1'b0, 32'h0, 32'h0, 16'd1024, 16'd1024, 1'b0);
        smp();
        chk("saturated drop_count", 32'(drop_count), 32'd255);
        chk("saturated overflow", 32'(overflow), 32'h1);
        drive(1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 16'd1024, 16'd1024, 1'b1);
        nxt();
        drive(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b0);
        smp();
        chk("clr overflow/drop", {23'h0, overflow, drop_count}, 32'h0);
        chk("clr ready/idle", {30'h0, ready_in, idle}, 32'h3);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("post-clr quiet%0d", c), 32'(wr_out_result | wr_out_status), 32'h0);
            nxt(); smp();
        end
        nxt();

        // Strobe coinciding with clr on an empty queue is ignored
        drive(1'b1, 32'h7777_7777, 32'h8888_8888, 16'h0, 16'h0, 1'b1);
        nxt();
        drive(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            smp();
            chk($sformatf("clr+strobe idle%0d", c), {31'h0, idle}, 32'h1);
            chk($sformatf("clr+strobe quiet%0d", c), 32'(wr_out_result), 32'h0);
            nxt();
        end

        // clr during WR_HI with two pairs still queued
        drive(1'b1, 32'h0011_0010, 32'h0111_0110, 16'h0, 16'h0, 1'b0); nxt();
        drive(1'b1, 32'h0021_0020, 32'h0121_0120, 16'h0, 16'h0, 1'b0); nxt();
        drive(1'b1, 32'h0031_0030, 32'h0131_0130, 16'h0, 16'h0, 1'b0); nxt();
        drive(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b0);
        smp();
        chk("pre-clr WR_HI data", {data_out_result, data_out_status}, {16'h0011, 16'h0111});
        clr_in = 1'b1;
        nxt();
        clr_in = 1'b0;
        smp();
        chk("clr WR_HI idle/ovf/drop", {22'h0, idle, overflow, drop_count}, {22'h0, 1'b1, 1'b0, 8'h0});
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("clr WR_HI quiet%0d", c), 32'(wr_out_result | wr_out_status), 32'h0);
            nxt(); smp();
        end
        nxt();

        // Asynchronous reset in the middle of WR_LO
        drive(1'b1, 32'h5678_9ABC, 32'h4321_0FED, 16'h0, 16'h0, 1'b0); nxt();
        drive(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b0); nxt();
        smp();
        chk("pre-rst WR_LO", {15'h0, wr_out_result, data_out_result}, {15'h0, 1'b1, 16'h9ABC});
        #1 rst = 1'b1;
        #1;
        chk("async rst wr", 32'(wr_out_result | wr_out_status), 32'h0);
        chk("async rst ready/idle", {30'h0, ready_in, idle}, 32'h3);
        chk("async rst data", {data_out_result, data_out_status}, 32'h0);
        nxt(); nxt();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            smp();
            chk($sformatf("post-rst quiet%0d", c), 32'(wr_out_result | wr_out_status), 32'h0);
            nxt();
        end
        drive(1'b1, 32'hBEEF_CAFE, 32'h0002_0003, 16'h0, 16'h0, 1'b0); nxt();
        drive(1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b0); nxt();
        smp();
        chk("post-rst lo", {15'h0, wr_out_status, data_out_status}, {15'h0, 1'b1, 16'h0003});
        nxt(); smp();
        chk("post-rst hi", {data_out_result, data_out_status}, {16'hBEEF, 16'h0002});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
